// File: rtl/rv32i_mem_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between the rv32i instruction
// fetch port and the data load/store port, one transaction at a time.
module rv32i_mem_arbiter #(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned ARB_MODE    = 0
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wmask,
  output logic        d_ack,
  output logic [31:0] d_rdata,

  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,

  output logic        owner_d
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  state_t     state, state_nx;
  logic [3:0] cnt;
  logic       last_d;
  logic       grant;
  logic       grant_d;

  // Tie-break: fixed mode always favours data; round-robin favours whoever
  // did not win last time, so data wins the first tie after reset.
  always_comb begin
    grant = i_req | d_req;
    if (i_req && d_req) begin
      grant_d = (ARB_MODE != 0) ? 1'b1 : ~last_d;
    end else begin
      grant_d = d_req;
    end
  end

  // NOTE: every output of a combinational block gets a default before the
  // case statement, otherwise unassigned paths infer latches.
  always_comb begin
    state_nx = state;
    mem_en   = 1'b0;
    i_ack    = 1'b0;
    d_ack    = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant) state_nx = ACCESS;
      end
      ACCESS: begin
        mem_en   = 1'b1;
        state_nx = mem_we ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt == 4'd1) state_nx = RESP;
      end
      RESP: begin
        d_ack    = owner_d;
        i_ack    = ~owner_d;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 4'd0;
      last_d    <= 1'b0;
      owner_d   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_wmask <= 4'd0;
      i_rdata   <= 32'd0;
      d_rdata   <= 32'd0;
    end else begin
      if (state == IDLE && grant) begin
        owner_d <= grant_d;
        last_d  <= grant_d;
        if (grant_d) begin
          mem_addr  <= d_addr;
          mem_we    <= d_we;
          mem_wdata <= d_we ? d_wdata : 32'd0;
          mem_wmask <= d_we ? d_wmask : 4'd0;
        end else begin
          mem_addr  <= i_addr;
          mem_we    <= 1'b0;
          mem_wdata <= 32'd0;
          mem_wmask <= 4'd0;
        end
      end

      if (state == ACCESS) begin
        cnt <= LAT;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end

      // Read data is only valid in the final wait cycle; capture it there.
      if (state == WAIT && cnt == 4'd1) begin
        if (owner_d) begin
          d_rdata <= mem_rdata;
        end else begin
          i_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule
